rr_timeout_arbiter: RTL
=======================

RR_TIMEOUT_ARBITER -- requirements
Module: rr_timeout_arbiter

Interface
REQ-001 Parameter NPORTS, default 5: number of requesting input ports (2..16).
REQ-002 Parameter LEN_W, default 12: width of the per-port timeout length field.
REQ-003 Parameter FID_W, default 3: width of the per-port flit-id field.
REQ-004 Parameter TAIL_RELEASE, default 1: when 1, a tail flit on the granted port releases the grant.
REQ-005 Port clk  input  1  clock; all state updates on the rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port req  input  NPORTS  per-port request, bit i = port i.
REQ-008 Port flit_id  input  NPORTS*FID_W  per-port flit type; port i occupies bits [i*FID_W +: FID_W].
REQ-009 Port length  input  NPORTS*LEN_W  per-port packet length, sampled on header flits.
REQ-010 Port grant  output  NPORTS  registered one-hot grant; all-zero when idle.
REQ-011 Port grant_valid  output  1  registered; high iff grant is non-zero.
REQ-012 Port timeout_evt  output  1  registered one-cycle pulse when a grant is revoked by timeout.

Function
REQ-013 The FSM SHALL have two states: IDLE (no grant) and GRANT (exactly one grant bit set).
REQ-014 Flit ids SHALL decode as HEADER=3'b001 and TAIL=3'b100; other codes are body flits.
REQ-015 Each port SHALL latch length into its limit register in every cycle its flit_id equals HEADER, whether or not the port is granted.
REQ-016 Arbitration SHALL be round-robin: the winner is the first port with req high, searching from ptr upward modulo NPORTS.
REQ-017 ptr SHALL become (winner+1) mod NPORTS on every new grant.
REQ-018 In IDLE with any req high, grant SHALL assert on the next edge (one-cycle latency); with no req high, the FSM stays in IDLE.
REQ-019 The grant counter SHALL clear on a new grant and increment by 1 in each cycle the grant is held, saturating at 2^LEN_W-1.
REQ-020 The grant to port g SHALL be released at the edge following: req[g] low; OR counter equal to max(limit[g],1)-1 (timeout); OR (TAIL_RELEASE and flit_id[g]==TAIL with req[g] high).
REQ-021 On release, the next winner SHALL be chosen in the same cycle, so grant moves with no idle gap; if no port requests, the FSM enters IDLE.
REQ-022 A port released by timeout that still requests SHALL compete normally; if it is the sole requester it is re-granted with the counter cleared.
REQ-023 timeout_evt SHALL pulse for one cycle, coincident with the new grant value, only when the release cause is timeout with req[g] still high.
REQ-024 If timeout and tail occur in the same cycle, the release SHALL be treated as a tail release and timeout_evt stays low.
REQ-025 A header arriving on the granted port SHALL update limit for the next cycle; the compare in the current cycle uses the old limit.

Reset
REQ-026 On rst: grant=0, grant_valid=0, timeout_evt=0, ptr=0, counter=0, all limits=0, state=IDLE, effective at the next edge.
REQ-027 rst asserted mid-grant SHALL drop the grant at that edge; req is ignored while rst is high.

Structure
REQ-028 Package arb_pkg SHALL hold the HEADER/TAIL flit-id constants and the IDLE/GRANT state type.
REQ-029 Per-port limit storage and the header latch SHALL be a sub-module arb_port_limit, instantiated NPORTS times by generate; arbitration and the counter stay in the top level.

Verification
REQ-030 Reset, then req=5'b00110 held -> grant=5'b00010 after 1 cycle; after port 1 releases, grant=5'b00100.
REQ-031 All 5 req high, each dropped after 2 grant cycles -> grant sequence 0,1,2,3,4,0 with no idle cycle.
REQ-032 Port 2 header with length=4, req[2] held, ports 0/3 also requesting -> grant[2] for exactly 4 cycles, timeout_evt=1 once, grant moves to port 3.
REQ-033 TAIL_RELEASE=1: tail flit on granted port 1 in cycle 3 of 10-cycle limit -> grant leaves port 1 at the next edge, timeout_evt=0.
REQ-034 Port 0 sole requester with limit=0 -> grant re-issued to port 0 every cycle, timeout_evt high each cycle.
REQ-035 rst pulsed during grant to port 4 -> grant=0 next edge; after release, req=5'b10001 -> port 0 granted (ptr=0).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared flit-id codes and arbiter FSM state type.
package arb_pkg;
   localparam logic [2:0] FLIT_HEADER = 3'b001;
   localparam logic [2:0] FLIT_TAIL   = 3'b100;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;
endpackage

// File: rtl/arb_port_limit.sv
// Per-port timeout limit: captures the length field on every header flit,
// granted or not; the new value is visible from the following cycle.
module arb_port_limit
   import arb_pkg::*;
#(
   parameter int LEN_W = 12,
   parameter int FID_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FID_W-1:0] i_flit_id,
   input  logic [LEN_W-1:0] i_length,
   output logic [LEN_W-1:0] o_limit
);
   logic [LEN_W-1:0] r_limit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_limit <= '0;
      end else if (i_flit_id == FID_W'(FLIT_HEADER)) begin
         r_limit <= i_length;
      end
   end

   assign o_limit = r_limit;
endmodule

// File: rtl/rr_timeout_arbiter.sv
// Round-robin arbiter with per-port timeout and optional tail release;
// registered one-hot grant, handover to the next winner with no idle gap.
module rr_timeout_arbiter
   import arb_pkg::*;
#(
   parameter int NPORTS       = 5,
   parameter int LEN_W        = 12,
   parameter int FID_W        = 3,
   parameter int TAIL_RELEASE = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NPORTS-1:0]       req,
   input  logic [NPORTS*FID_W-1:0] flit_id,
   input  logic [NPORTS*LEN_W-1:0] length,
   output logic [NPORTS-1:0]       grant,
   output logic                    grant_valid,
   output logic                    timeout_evt
);
   localparam int IDX_W = $clog2(NPORTS);
   localparam logic [LEN_W-1:0] CNT_MAX = '1;

   arb_state_e        r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
   logic [IDX_W-1:0]  r_gidx, w_gidx_nxt;
   logic [IDX_W-1:0]  w_win, w_idx;
   logic              w_win_vld;
   logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
   logic [NPORTS-1:0] r_grant, w_grant_nxt;
   logic              r_grant_vld;
   logic              r_tout, w_tout_nxt;
   logic [LEN_W-1:0]  w_limit [NPORTS];
   logic [NPORTS-1:0] w_is_tail;
   logic [LEN_W-1:0]  w_lim_eff;
   logic              w_req_g, w_tail_g, w_tmo_g, w_release;

   for (genvar i = 0; i < NPORTS; i++) begin : g_port
      arb_port_limit #(
         .LEN_W (LEN_W),
         .FID_W (FID_W)
      ) u_limit (
         .clk       (clk),
         .rst       (rst),
         .i_flit_id (flit_id[i*FID_W +: FID_W]),
         .i_length  (length[i*LEN_W +: LEN_W]),
         .o_limit   (w_limit[i])
      );
      assign w_is_tail[i] = (flit_id[i*FID_W +: FID_W] == FID_W'(FLIT_TAIL));
   end

   // Descending scan so the lowest offset from ptr is the last (winning) write.
   always_comb begin
      w_win     = '0;
      w_win_vld = 1'b0;
      w_idx     = '0;
      for (int k = NPORTS-1; k >= 0; k--) begin
         w_idx = IDX_W'((int'(r_ptr) + k) % NPORTS);
         if (req[w_idx]) begin
            w_win     = w_idx;
            w_win_vld = 1'b1;
         end
      end
   end

   // A zero limit behaves like one: the grant lasts a single cycle.
   always_comb begin
      w_lim_eff = (w_limit[r_gidx] == '0) ? LEN_W'(1) : w_limit[r_gidx];
      w_req_g   = req[r_gidx];
      w_tail_g  = (TAIL_RELEASE != 0) && w_is_tail[r_gidx] && w_req_g;
      w_tmo_g   = (r_cnt == w_lim_eff - LEN_W'(1));
      w_release = !w_req_g || w_tmo_g || w_tail_g;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_gidx_nxt  = r_gidx;
      w_cnt_nxt   = r_cnt;
      w_grant_nxt = r_grant;
      w_tout_nxt  = 1'b0;
      if (r_state == ST_IDLE || w_release) begin
         if (r_state == ST_GRANT) begin
            w_tout_nxt = w_tmo_g && w_req_g && !w_tail_g;
         end
         if (w_win_vld) begin
            w_state_nxt = ST_GRANT;
            w_grant_nxt = NPORTS'(1) << w_win;
            w_gidx_nxt  = w_win;
            w_ptr_nxt   = (w_win == IDX_W'(NPORTS-1)) ? '0 : w_win + 1'b1;
            w_cnt_nxt   = '0;
         end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
         end
      end else if (r_cnt != CNT_MAX) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_gidx      <= '0;
         r_cnt       <= '0;
         r_grant     <= '0;
         r_grant_vld <= 1'b0;
         r_tout      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ptr       <= w_ptr_nxt;
         r_gidx      <= w_gidx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_grant     <= w_grant_nxt;
         r_grant_vld <= |w_grant_nxt;
         r_tout      <= w_tout_nxt;
      end
   end

   assign grant       = r_grant;
   assign grant_valid = r_grant_vld;
   assign timeout_evt = r_tout;
endmodule
